dice_referee: RTL and testbench

- Consumes the two dice values and the player roll buttons, decides each round and keeps the match score.
- Detects end of a roll: both start lines low and both dice values stable for SETTLE_CYCLES clocks.
- Latches both dice, compares them and updates saturating scores.
- Drives finish high when a player reaches WIN_SCORE, which freezes the dice generators until clear.

---
 rtl/dice_referee.sv | 176 +++++++++++++++++
 tb/tb_dice_referee.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dice_referee.sv
// Two-player dice round referee: waits for both dice to settle after a roll,
// decides the round, keeps saturating scores and freezes the match on a win.
module dice_referee #(
  parameter int SETTLE_CYCLES = 300,
  parameter int WIN_SCORE     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start1,
  input  logic       start2,
  input  logic [3:0] dice1,
  input  logic [3:0] dice2,
  input  logic       clear,
  output logic [3:0] res1,
  output logic [3:0] res2,
  output logic [1:0] round_winner,
  output logic       result_valid,
  output logic       bad_roll,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic       finish,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, ROLL, SETTLE, DECIDE, OVER} state_t;

  localparam logic [9:0] CNT_LAST = 10'(SETTLE_CYCLES - 1);
  localparam logic [3:0] WIN      = 4'(WIN_SCORE);

  state_t     state_reg, state_next;
  logic [9:0] cnt_reg, cnt_next;
  logic [3:0] snap1_reg, snap1_next, snap2_reg, snap2_next;
  logic [3:0] res1_reg, res1_next, res2_reg, res2_next;
  logic [1:0] rw_reg, rw_next;
  logic       rv_reg, rv_next, bad_reg, bad_next;
  logic [3:0] score1_reg, score1_next, score2_reg, score2_next;
  logic [1:0] winner_reg, winner_next;
  logic       any_start;
  logic [3:0] s1_inc, s2_inc;

  assign any_start = start1 | start2;
  assign s1_inc    = (score1_reg == 4'd15) ? 4'd15 : score1_reg + 4'd1;
  assign s2_inc    = (score2_reg == 4'd15) ? 4'd15 : score2_reg + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      snap1_reg  <= '0;
      snap2_reg  <= '0;
      res1_reg   <= '0;
      res2_reg   <= '0;
      rw_reg     <= '0;
      rv_reg     <= 1'b0;
      bad_reg    <= 1'b0;
      score1_reg <= '0;
      score2_reg <= '0;
      winner_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      snap1_reg  <= snap1_next;
      snap2_reg  <= snap2_next;
      res1_reg   <= res1_next;
      res2_reg   <= res2_next;
      rw_reg     <= rw_next;
      rv_reg     <= rv_next;
      bad_reg    <= bad_next;
      score1_reg <= score1_next;
      score2_reg <= score2_next;
      winner_reg <= winner_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    snap1_next  = snap1_reg;
    snap2_next  = snap2_reg;
    res1_next   = res1_reg;
    res2_next   = res2_reg;
    rw_next     = rw_reg;
    rv_next     = 1'b0;
    bad_next    = 1'b0;
    score1_next = score1_reg;
    score2_next = score2_reg;
    winner_next = winner_reg;

    case (state_reg)
      IDLE: begin
        if (any_start) state_next = ROLL;
      end
      ROLL: begin
        if (!any_start) begin
          state_next = SETTLE;
          snap1_next = dice1;
          snap2_next = dice2;
          cnt_next   = '0;
        end
      end
      SETTLE: begin
        if (any_start) begin
          state_next = ROLL;
        end else if (dice1 != snap1_reg || dice2 != snap2_reg) begin
          // Any movement on either die restarts the stability window.
          snap1_next = dice1;
          snap2_next = dice2;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = DECIDE;
        end else begin
          cnt_next = cnt_reg + 10'd1;
        end
      end
      DECIDE: begin
        res1_next = snap1_reg;
        res2_next = snap2_reg;
        rv_next   = 1'b1;
        if (snap1_reg > 4'd9 || snap2_reg > 4'd9) begin
          rw_next  = 2'b00;
          bad_next = 1'b1;
        end else if (snap1_reg > snap2_reg) begin
          rw_next     = 2'b01;
          score1_next = s1_inc;
        end else if (snap2_reg > snap1_reg) begin
          rw_next     = 2'b10;
          score2_next = s2_inc;
        end else begin
          rw_next = 2'b11;
        end
        // Only one score moves per round, so at most one player can hit the target.
        if (score1_next == WIN) begin
          state_next  = OVER;
          winner_next = 2'b01;
        end else if (score2_next == WIN) begin
          state_next  = OVER;
          winner_next = 2'b10;
        end else begin
          state_next = IDLE;
        end
      end
      OVER: begin
        state_next = OVER;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (clear) begin
      state_next  = IDLE;
      cnt_next    = '0;
      res1_next   = '0;
      res2_next   = '0;
      rw_next     = 2'b00;
      rv_next     = 1'b0;
      bad_next    = 1'b0;
      score1_next = '0;
      score2_next = '0;
      winner_next = 2'b00;
    end
  end

  assign res1         = res1_reg;
  assign res2         = res2_reg;
  assign round_winner = rw_reg;
  assign result_valid = rv_reg;
  assign bad_roll     = bad_reg;
  assign score1       = score1_reg;
  assign score2       = score2_reg;
  assign winner       = winner_reg;
  assign finish       = (state_reg == OVER);
  assign busy         = (state_reg == ROLL) || (state_reg == SETTLE);

endmodule

// File: tb/tb_dice_referee.sv
// Scoreboard bench for dice_referee: directed rounds push expected decisions,
// a negedge monitor pops and checks them when result_valid appears.
module tb_dice_referee;
  localparam int SC = 4;
  localparam int WS = 3;

  logic       clk = 1'b0;
  logic       rst, start1, start2, clear;
  logic [3:0] dice1, dice2;
  logic [3:0] res1, res2, score1, score2;
  logic [1:0] round_winner, winner;
  logic       result_valid, bad_roll, finish, busy;

  dice_referee #(.SETTLE_CYCLES(SC), .WIN_SCORE(WS)) dut (
    .clk(clk), .rst(rst), .start1(start1), .start2(start2),
    .dice1(dice1), .dice2(dice2), .clear(clear),
    .res1(res1), .res2(res2), .round_winner(round_winner),
    .result_valid(result_valid), .bad_roll(bad_roll),
    .score1(score1), .score2(score2), .winner(winner),
    .finish(finish), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         at;
    logic [3:0] r1, r2;
    logic [1:0] rw;
    logic       bad;
    logic [3:0] s1, s2;
    logic       fin;
    logic [1:0] win;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int at, input logic [3:0] r1, input logic [3:0] r2,
                      input logic [1:0] rw, input logic bad, input logic [3:0] s1,
                      input logic [3:0] s2, input logic fin, input logic [1:0] win);
    exp_t e;
    e.at = at; e.r1 = r1; e.r2 = r2; e.rw = rw; e.bad = bad;
    e.s1 = s1; e.s2 = s2; e.fin = fin; e.win = win;
    q.push_back(e);
  endtask

  // Full round: hold a start button 10 clocks, release, expect a decision 6 clocks later.
  task automatic roll(input bit p2, input logic [3:0] d1, input logic [3:0] d2,
                      input logic [1:0] rw, input logic bad, input logic [3:0] s1,
                      input logic [3:0] s2, input logic fin, input logic [1:0] win);
    dice1 = d1; dice2 = d2;
    if (p2) start2 = 1'b1; else start1 = 1'b1;
    tick(10);
    start1 = 1'b0; start2 = 1'b0;
    push(cyc + 6, d1, d2, rw, bad, s1, s2, fin, win);
    tick(8);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bad_roll && !result_valid) chk("bad_roll_without_valid", 32'(bad_roll), 0);
      if (result_valid) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result_valid: got valid at cycle %0d expected none", cyc);
        end else begin
          e = q.pop_front();
          $display("decision @%0d: res=%0d/%0d rw=%0d bad=%0d score=%0d/%0d finish=%0d winner=%0d",
                   cyc, res1, res2, round_winner, bad_roll, score1, score2, finish, winner);
          chk("valid_cycle", cyc, e.at);
          chk("res1", 32'(res1), 32'(e.r1));
          chk("res2", 32'(res2), 32'(e.r2));
          chk("round_winner", 32'(round_winner), 32'(e.rw));
          chk("bad_roll", 32'(bad_roll), 32'(e.bad));
          chk("score1", 32'(score1), 32'(e.s1));
          chk("score2", 32'(score2), 32'(e.s2));
          chk("finish", 32'(finish), 32'(e.fin));
          chk("winner", 32'(winner), 32'(e.win));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; clear = 1'b0;
    dice1 = 4'd0; dice2 = 4'd0;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_finish", 32'(finish), 0);
    chk("rst_score1", 32'(score1), 0);
    chk("rst_res1", 32'(res1), 0);
    chk("rst_winner", 32'(winner), 0);

    // Basic round 7 vs 3.
    roll(0, 4'd7, 4'd3, 2'b01, 1'b0, 4'd1, 4'd0, 1'b0, 2'b00);
    chk("basic_busy_after", 32'(busy), 0);

    // Instability: dice2 moves 5->6 two clocks into SETTLE.
    dice1 = 4'd2; dice2 = 4'd5; start2 = 1'b1;
    tick(3);
    start2 = 1'b0;
    tick(2);
    chk("settle_busy", 32'(busy), 1);
    dice2 = 4'd6;
    push(cyc + 6, 4'd2, 4'd6, 2'b10, 1'b0, 4'd1, 4'd1, 1'b0, 2'b00);
    tick(10);

    // Re-press during SETTLE: only the final release produces a decision.
    dice1 = 4'd5; dice2 = 4'd1; start1 = 1'b1;
    tick(3);
    start1 = 1'b0;
    tick(2);
    start2 = 1'b1;
    tick(3);
    start2 = 1'b0;
    push(cyc + 6, 4'd5, 4'd1, 2'b01, 1'b0, 4'd2, 4'd1, 1'b0, 2'b00);
    tick(8);

    // Tie and invalid roll leave scores alone.
    roll(1, 4'd4, 4'd4, 2'b11, 1'b0, 4'd2, 4'd1, 1'b0, 2'b00);
    roll(0, 4'd12, 4'd3, 2'b00, 1'b1, 4'd2, 4'd1, 1'b0, 2'b00);

    // Asynchronous reset in SETTLE with score1=2.
    dice1 = 4'd8; dice2 = 4'd2; start1 = 1'b1;
    tick(3);
    start1 = 1'b0;
    tick(2);
    chk("pre_reset_busy", 32'(busy), 1);
    chk("pre_reset_score1", 32'(score1), 2);
    rst = 1'b1;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_score1", 32'(score1), 0);
    chk("async_score2", 32'(score2), 0);
    chk("async_res1", 32'(res1), 0);
    chk("async_round_winner", 32'(round_winner), 0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);

    // Player 2 wins the match in three rounds.
    roll(1, 4'd1, 4'd8, 2'b10, 1'b0, 4'd0, 4'd1, 1'b0, 2'b00);
    roll(1, 4'd0, 4'd9, 2'b10, 1'b0, 4'd0, 4'd2, 1'b0, 2'b00);
    roll(1, 4'd3, 4'd5, 2'b10, 1'b0, 4'd0, 4'd3, 1'b1, 2'b10);

    // Starts ignored once the match is over.
    dice1 = 4'd9; dice2 = 4'd0; start1 = 1'b1;
    tick(3);
    start1 = 1'b0;
    tick(15);
    chk("over_finish", 32'(finish), 1);
    chk("over_winner", 32'(winner), 2);
    chk("over_score2", 32'(score2), 3);
    chk("over_score1", 32'(score1), 0);
    chk("over_busy", 32'(busy), 0);

    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clear_finish", 32'(finish), 0);
    chk("clear_winner", 32'(winner), 0);
    chk("clear_score2", 32'(score2), 0);
    chk("clear_round_winner", 32'(round_winner), 0);
    chk("clear_res2", 32'(res2), 0);
    chk("clear_busy", 32'(busy), 0);

    // New match starts from IDLE after clear.
    roll(0, 4'd9, 4'd0, 2'b01, 1'b0, 4'd1, 4'd0, 1'b0, 2'b00);

    for (int i = 0; i < 20 && q.size() != 0; i++) tick(1);
    if (q.size() != 0) chk("pending_results", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
